// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op indices and inter-stage bundles for the execute stage.
// ES_FWD_EN adds the execute-to-decode forwarding bus.
package ex_stage_pkg;

  localparam int DS_TO_ES_WD = 148;
  localparam int ES_TO_MS_WD = 71;
  localparam int ES_FWD_WD   = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef struct packed {
    logic        rf_or_mem;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  dest;
    logic [11:0] alu_op;
    logic [31:0] pc;
    logic [31:0] rkd_value;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
  } ds_to_es_t;

  typedef struct packed {
    logic        rf_or_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] alu_result;
  } es_to_ms_t;

  typedef struct packed {
    logic        fwd_valid;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] alu_result;
  } es_fwd_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Single-cycle combinational ALU, one-hot op select.
// An all-zero op yields zero.
module alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  logic [32:0] diff;
  logic        slt;
  logic        sltu;

  assign diff = {1'b0, src1} - {1'b0, src2};
  assign sltu = diff[32];
  // Sign differs: A negative wins; same sign: sign of the difference.
  assign slt  = (src1[31] & ~src2[31])
              | (~(src1[31] ^ src2[31]) & diff[31]);

  always_comb begin
    result = '0;
    unique case (1'b1)
      alu_op[ALU_ADD]:  result = src1 + src2;
      alu_op[ALU_SUB]:  result = diff[31:0];
      alu_op[ALU_SLT]:  result = {31'd0, slt};
      alu_op[ALU_SLTU]: result = {31'd0, sltu};
      alu_op[ALU_AND]:  result = src1 & src2;
      alu_op[ALU_NOR]:  result = ~(src1 | src2);
      alu_op[ALU_OR]:   result = src1 | src2;
      alu_op[ALU_XOR]:  result = src1 ^ src2;
      alu_op[ALU_SLL]:  result = src1 << src2[4:0];
      alu_op[ALU_SRL]:  result = src1 >> src2[4:0];
      alu_op[ALU_SRA]:  result = $signed(src1) >>> src2[4:0];
      alu_op[ALU_LUI]:  result = src2;
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: handshake, payload register, ALU and data-SRAM request.
// Define ES_FWD_EN to expose es_fwd_bus for decode forwarding.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ds_to_es_valid,
  input  logic [DS_TO_ES_WD-1:0] ds_to_es_bus,
  output logic                   es_allow_in,
  input  logic                   ms_allow_in,
  output logic                   es_to_ms_valid,
  output logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata
`ifdef ES_FWD_EN
  ,
  output logic [ES_FWD_WD-1:0]   es_fwd_bus
`endif
);

  logic        es_valid;
  logic        es_ready_go;
  logic        es_go;
  ds_to_es_t   es_pl;
  es_to_ms_t   ms_pl;
  logic [31:0] alu_result;

  assign es_ready_go    = 1'b1;
  assign es_to_ms_valid = es_valid & es_ready_go;
  assign es_allow_in    = !es_valid | (es_ready_go & ms_allow_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      es_valid <= 1'b0;
    end else if (es_allow_in) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      es_pl <= '0;
    end else if (ds_to_es_valid && es_allow_in) begin
      es_pl <= ds_to_es_t'(ds_to_es_bus);
    end
  end

  alu u_alu (
    .alu_op (es_pl.alu_op),
    .src1   (es_pl.alu_src1),
    .src2   (es_pl.alu_src2),
    .result (alu_result)
  );

  assign ms_pl.rf_or_mem  = es_pl.rf_or_mem;
  assign ms_pl.rf_we      = es_pl.rf_we;
  assign ms_pl.dest       = es_pl.dest;
  assign ms_pl.pc         = es_pl.pc;
  assign ms_pl.alu_result = alu_result;
  assign es_to_ms_bus     = ms_pl;

  // Request only on the transfer cycle so a stalled store writes once.
  assign es_go           = es_valid & ms_allow_in;
  assign data_sram_en    = es_go & (es_pl.rf_or_mem | es_pl.mem_we);
  assign data_sram_we    = {4{es_go & es_pl.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_pl.rkd_value;

`ifdef ES_FWD_EN
  es_fwd_t fwd;

  assign fwd.fwd_valid  = es_valid & es_pl.rf_we;
  assign fwd.is_load    = es_pl.rf_or_mem;
  assign fwd.dest       = es_pl.dest;
  assign fwd.alu_result = alu_result;
  assign es_fwd_bus     = fwd;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected ES->MS payloads queued on accept,
// popped by a monitor on each transfer.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct {
    logic [70:0] bus;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ds_to_es_valid;
  logic [DS_TO_ES_WD-1:0] ds_to_es_bus;
  logic                   es_allow_in;
  logic                   ms_allow_in;
  logic                   es_to_ms_valid;
  logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
  logic                   data_sram_en;
  logic [3:0]             data_sram_we;
  logic [31:0]            data_sram_addr;
  logic [31:0]            data_sram_wdata;
`ifdef ES_FWD_EN
  logic [ES_FWD_WD-1:0]   es_fwd_bus;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_allow_in     (es_allow_in),
    .ms_allow_in     (ms_allow_in),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
`ifdef ES_FWD_EN
    ,
    .es_fwd_bus      (es_fwd_bus)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(int op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  r = (a < b) ? 32'd1 : 32'd0;
      4:  r = a & b;
      5:  r = ~(a | b);
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = a << b[4:0];
      9:  r = a >> b[4:0];
      10: r = $signed(a) >>> b[4:0];
      11: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ds(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rkd, input logic rom, input logic mwe,
                         input logic rwe, input logic [4:0] dest,
                         input logic [31:0] pc, output exp_t e);
    logic [11:0] opv;
    logic [31:0] res;
    opv = (op >= 0) ? (12'd1 << op) : 12'd0;
    res = model(op, a, b);
    ds_to_es_bus   = {rom, mwe, rwe, dest, opv, pc, rkd, a, b};
    ds_to_es_valid = 1'b1;
    e.bus   = {rom, rwe, dest, pc, res};
    e.en    = rom | mwe;
    e.we    = mwe ? 4'hF : 4'h0;
    e.addr  = res;
    e.wdata = rkd;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (es_to_ms_valid && ms_allow_in) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_extra: transfer pc=%h with empty scoreboard",
                   es_to_ms_bus[63:32]);
        end else begin
          e = sb.pop_front();
          if ({es_to_ms_bus, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}
              !== {e.bus, e.en, e.we, e.addr, e.wdata}) begin
            n_bad++;
            $display("FAIL sb_xfer: got bus=%h en=%b we=%h addr=%h wd=%h exp bus=%h en=%b we=%h addr=%h wd=%h",
                     es_to_ms_bus, data_sram_en, data_sram_we, data_sram_addr,
                     data_sram_wdata, e.bus, e.en, e.we, e.addr, e.wdata);
          end
        end
      end else begin
        n_cmp++;
        if ({data_sram_en, data_sram_we} !== 5'b0) begin
          n_bad++;
          $display("FAIL sb_idle_sram: got en=%b we=%h exp en=0 we=0",
                   data_sram_en, data_sram_we);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    ms_allow_in = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    #3;
    n_cmp++;
    if ({es_to_ms_valid, es_allow_in, data_sram_en, data_sram_we, data_sram_addr,
         data_sram_wdata, es_to_ms_bus} !== {1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 71'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b ai=%b en=%b we=%h addr=%h wd=%h bus=%h exp v=0 ai=1 rest 0",
               es_to_ms_valid, es_allow_in, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, es_to_ms_bus);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    exp_t e;
    ms_allow_in = 1'b1;
    load_ds(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3,
            32'h1c00_0000, e);
    sb.push_back(e);
    tick();
    ds_to_es_valid = 1'b0;
    n_cmp++;
    if ({es_to_ms_valid, es_to_ms_bus[31:0], data_sram_en} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      n_bad++;
      $display("FAIL add_ovf: got v=%b res=%h en=%b exp v=1 res=80000000 en=0",
               es_to_ms_valid, es_to_ms_bus[31:0], data_sram_en);
    end
    tick();
  endtask

  task automatic test_alu_ops();
    exp_t e;
    logic [31:0] want [3];
    int ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    ops = '{ALU_SLT, ALU_SLTU, ALU_SRA};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'h1, 32'h1, 32'h24};
    want = '{32'h1, 32'h0, 32'hF800_0000};
    ms_allow_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_ds(ops[i], as[i], bs[i], 32'h0, 1'b0, 1'b0, 1'b1, 5'(i + 1),
              32'h1c00_0100 + 32'(i * 4), e);
      sb.push_back(e);
      tick();
      n_cmp++;
      if (es_to_ms_bus[31:0] !== want[i]) begin
        n_bad++;
        $display("FAIL alu_op%0d: got %h exp %h", ops[i], es_to_ms_bus[31:0], want[i]);
      end
    end
    ds_to_es_valid = 1'b0;
    // Sweep every op with random operands through the scoreboard.
    for (int op = -1; op < 12; op++) begin
      load_ds(op, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 5'(op + 2),
              32'h1c00_0200 + 32'((op + 1) * 4), e);
      sb.push_back(e);
      tick();
    end
    ds_to_es_valid = 1'b0;
    tick();
  endtask

  task automatic test_store_stall();
    exp_t e;
    int en_cnt;
    en_cnt = 0;
    ms_allow_in = 1'b0;
    load_ds(ALU_ADD, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0,
            32'h1c00_0300, e);
    sb.push_back(e);
    tick();
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({data_sram_en, data_sram_we, es_allow_in, data_sram_addr} !==
          {1'b0, 4'h0, 1'b0, 32'h1000}) begin
        n_bad++;
        $display("FAIL store_stall%0d: got en=%b we=%h ai=%b addr=%h exp en=0 we=0 ai=0 addr=1000",
                 i, data_sram_en, data_sram_we, es_allow_in, data_sram_addr);
      end
      tick();
    end
    ms_allow_in = 1'b1;
    #1;
    n_cmp++;
    if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !==
        {1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL store_fire: got en=%b we=%h addr=%h wd=%h exp en=1 we=f addr=1000 wd=deadbeef",
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      if (data_sram_en) en_cnt++;
      tick();
    end
    n_cmp++;
    if (en_cnt !== 1) begin
      n_bad++;
      $display("FAIL store_once: got %0d enable cycles exp 1", en_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic ms_pat [5];
    logic ai_exp [5];
    int   idx;
    ms_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ai_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      ms_allow_in = ms_pat[c];
      if (idx < 4)
        load_ds(ALU_ADD, 32'(100 * (idx + 1)), 32'(idx), 32'h0, 1'b0, 1'b0, 1'b1,
                5'(10 + idx), 32'h1c00_0400 + 32'(idx * 4), e);
      #1;
      n_cmp++;
      if (es_allow_in !== ai_exp[c]) begin
        n_bad++;
        $display("FAIL b2b_allow_c%0d: got %b exp %b", c, es_allow_in, ai_exp[c]);
      end
      if (ai_exp[c] && idx < 4) begin
        sb.push_back(e);
        idx++;
      end
      tick();
    end
    ds_to_es_valid = 1'b0;
    ms_allow_in = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got %0d pending exp 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    ms_allow_in = 1'b0;
    load_ds(ALU_ADD, 32'h2000, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5,
            32'h1c00_0500, e);
    tick();
    ds_to_es_valid = 1'b0;
    tick();
    n_cmp++;
    if ({es_to_ms_valid, data_sram_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL load_stall: got v=%b en=%b exp v=1 en=0", es_to_ms_valid, data_sram_en);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({es_to_ms_valid, es_allow_in, data_sram_en, data_sram_we, data_sram_addr,
         data_sram_wdata, es_to_ms_bus} !== {1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 71'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: got v=%b ai=%b en=%b we=%h addr=%h wd=%h bus=%h exp v=0 ai=1 rest 0",
               es_to_ms_valid, es_allow_in, data_sram_en, data_sram_we,
               data_sram_addr, data_sram_wdata, es_to_ms_bus);
    end
    tick();
    rst = 1'b1;
    ms_allow_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({es_allow_in, es_to_ms_valid, data_sram_en} !== 3'b100) begin
        n_bad++;
        $display("FAIL post_reset%0d: got ai=%b v=%b en=%b exp ai=1 v=0 en=0",
                 i, es_allow_in, es_to_ms_valid, data_sram_en);
      end
    end
  endtask

`ifdef ES_FWD_EN
  task automatic test_fwd();
    exp_t e;
    ms_allow_in = 1'b0;
    load_ds(ALU_ADD, 32'h3000, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5,
            32'h1c00_0600, e);
    sb.push_back(e);
    tick();
    ds_to_es_valid = 1'b0;
    n_cmp++;
    if (es_fwd_bus !== {1'b1, 1'b1, 5'd5, 32'h3010}) begin
      n_bad++;
      $display("FAIL fwd_load: got %h exp %h", es_fwd_bus, {1'b1, 1'b1, 5'd5, 32'h3010});
    end
    ms_allow_in = 1'b1;
    load_ds(ALU_ADD, 32'h1c00_0604, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 5'd1,
            32'h1c00_0604, e);
    sb.push_back(e);
    tick();
    ds_to_es_valid = 1'b0;
    n_cmp++;
    if (es_fwd_bus[38] !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd_bl: got fwd_valid=%b exp 0", es_fwd_bus[38]);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_store_stall();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef ES_FWD_EN
    test_fwd();
`endif
    tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_final: got %0d pending exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
